button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 126 ++++++++++++
 tb/tb_button_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchroniser, per-channel
// four-state debounce FSM, registered level and one-cycle press/release strobes.
module button_conditioner #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_strobe,
  output logic             any_press
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;

  // Private two-flop synchroniser per raw bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             rel_nxt;
    logic             level_nxt;
    logic             level_q;
    logic             press_q;
    logic             rel_q;

    // Debounce next-state: a level must hold for DEBOUNCE_CYCLES waiting cycles
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync[i]) begin
            state_nxt = WAIT_HI;
            cnt_nxt   = '0;
          end
        end
        WAIT_HI: begin
          if (!sync[i]) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync[i]) begin
            state_nxt = WAIT_LO;
            cnt_nxt   = '0;
          end
        end
        WAIT_LO: begin
          if (sync[i]) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
            rel_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end
      endcase
      level_nxt = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        state   <= STABLE_LO;
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        level_q <= level_nxt;
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
      end
    end

    assign level[i]          = level_q;
    assign press[i]          = press_q;
    assign release_strobe[i] = rel_q;
  end

  assign any_press = |press;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (WIDTH=4, DEBOUNCE_CYCLES=4):
// directed stimulus queues expected strobes and snapshots, a monitor checks them.
module tb_button_conditioner;

  logic       clk;
  logic       n_rst;
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_strobe;
  logic       any_press;

  button_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .raw            (raw),
    .level          (level),
    .press          (press),
    .release_strobe (release_strobe),
    .any_press      (any_press)
  );

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } exp_t;

  exp_t ev_q[$];
  exp_t snap_q[$];

  int   cyc = 0;
  int   applied = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
    applied++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, c, act, expv);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.level = l;
    ev_q.push_back(e);
  endtask

  task automatic push_snap(input int c, input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.level = l;
    snap_q.push_back(e);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops expected strobes when the DUT emits one, and timed snapshots
  always @(negedge clk) begin
    if (mon_en) begin
      if ((press & release_strobe) != 4'b0000)
        chk("press_and_release_overlap", cyc, 32'(press & release_strobe), 32'h0);
      if (any_press !== (|press))
        chk("any_press_vs_press", cyc, 32'(any_press), 32'(|press));
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        chk("missing_strobe_cycle", cyc, 32'(cyc), 32'(ev_q[0].cyc));
        void'(ev_q.pop_front());
      end
      if ((press | release_strobe) != 4'b0000) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_strobe", cyc, 32'({press, release_strobe}), 32'h0);
        end else begin
          exp_t e;
          e = ev_q.pop_front();
          chk("strobe_cycle", cyc, 32'(cyc), 32'(e.cyc));
          chk("strobe_press", cyc, 32'(press), 32'(e.press));
          chk("strobe_release", cyc, 32'(release_strobe), 32'(e.rel));
          chk("strobe_level", cyc, 32'(level), 32'(e.level));
          chk("strobe_any_press", cyc, 32'(any_press), 32'(|e.press));
        end
      end
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        exp_t s;
        s = snap_q.pop_front();
        if (s.cyc < cyc) begin
          chk("snapshot_missed", cyc, 32'(cyc), 32'(s.cyc));
        end else begin
          chk("snap_level", cyc, 32'(level), 32'(s.level));
          chk("snap_press", cyc, 32'(press), 32'(s.press));
          chk("snap_release", cyc, 32'(release_strobe), 32'(s.rel));
          chk("snap_any_press", cyc, 32'(any_press), 32'(|s.press));
        end
      end
    end
  end

  initial begin
    int t;
    n_rst = 1'b0;
    raw   = 4'b0000;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    push_snap(2, 4'b0000, 4'b0000, 4'b0000);
    goto_cyc(4);
    n_rst = 1'b1;

    // Single channel press then release
    goto_cyc(10);
    t = cyc;
    raw = 4'b0001;
    push_snap(t + 6, 4'b0000, 4'b0000, 4'b0000);
    push_ev(t + 7, 4'b0001, 4'b0000, 4'b0001);
    push_snap(t + 8, 4'b0001, 4'b0000, 4'b0000);
    goto_cyc(t + 12);
    raw = 4'b0000;
    push_snap(t + 18, 4'b0001, 4'b0000, 4'b0000);
    push_ev(t + 19, 4'b0000, 4'b0001, 4'b0000);
    push_snap(t + 20, 4'b0000, 4'b0000, 4'b0000);

    // 3-cycle glitch on channel 2 is rejected
    goto_cyc(t + 25);
    t = cyc;
    raw = 4'b0100;
    push_snap(t + 4, 4'b0000, 4'b0000, 4'b0000);
    push_snap(t + 7, 4'b0000, 4'b0000, 4'b0000);
    push_snap(t + 10, 4'b0000, 4'b0000, 4'b0000);
    goto_cyc(t + 3);
    raw = 4'b0000;

    // 4-cycle pulse still rejected: counter never reaches the accept point
    goto_cyc(t + 14);
    t = cyc;
    raw = 4'b0100;
    push_snap(t + 7, 4'b0000, 4'b0000, 4'b0000);
    push_snap(t + 9, 4'b0000, 4'b0000, 4'b0000);
    goto_cyc(t + 4);
    raw = 4'b0000;

    // 5-cycle pulse is the shortest accepted one
    goto_cyc(t + 14);
    t = cyc;
    raw = 4'b0100;
    push_ev(t + 7, 4'b0100, 4'b0000, 4'b0100);
    push_ev(t + 12, 4'b0000, 4'b0100, 4'b0000);
    goto_cyc(t + 5);
    raw = 4'b0000;

    // Channel 1 held 20 cycles
    goto_cyc(t + 18);
    t = cyc;
    raw = 4'b0010;
    push_ev(t + 7, 4'b0010, 4'b0000, 4'b0010);
    push_snap(t + 15, 4'b0010, 4'b0000, 4'b0000);
    push_ev(t + 27, 4'b0000, 4'b0010, 4'b0000);
    push_snap(t + 28, 4'b0000, 4'b0000, 4'b0000);
    goto_cyc(t + 20);
    raw = 4'b0000;

    // All four channels together
    goto_cyc(t + 32);
    t = cyc;
    raw = 4'b1111;
    push_ev(t + 7, 4'b1111, 4'b0000, 4'b1111);
    push_snap(t + 9, 4'b1111, 4'b0000, 4'b0000);
    push_ev(t + 19, 4'b0000, 4'b1111, 4'b0000);
    goto_cyc(t + 12);
    raw = 4'b0000;

    // Reset in the middle of a press aborts it; held button re-accepted
    goto_cyc(t + 24);
    t = cyc;
    raw = 4'b0001;
    push_snap(t + 4, 4'b0000, 4'b0000, 4'b0000);
    push_snap(t + 5, 4'b0000, 4'b0000, 4'b0000);
    goto_cyc(t + 5);
    n_rst = 1'b0;
    goto_cyc(t + 6);
    n_rst = 1'b1;
    push_snap(t + 7, 4'b0000, 4'b0000, 4'b0000);
    push_snap(t + 12, 4'b0000, 4'b0000, 4'b0000);
    push_ev(t + 13, 4'b0001, 4'b0000, 4'b0001);
    goto_cyc(t + 16);
    raw = 4'b0000;
    push_ev(t + 23, 4'b0000, 4'b0001, 4'b0000);

    // Channel 3 chatters every 2 cycles while channel 0 is pressed
    goto_cyc(t + 28);
    t = cyc;
    push_ev(t + 7, 4'b0001, 4'b0000, 4'b0001);
    push_snap(t + 10, 4'b0001, 4'b0000, 4'b0000);
    push_snap(t + 30, 4'b0001, 4'b0000, 4'b0000);
    push_snap(t + 50, 4'b0001, 4'b0000, 4'b0000);
    push_ev(t + 57, 4'b0000, 4'b0001, 4'b0000);
    push_snap(t + 60, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 25; k++) begin
      goto_cyc(t + 2 * k);
      raw = {(k % 2 == 0), 3'b001};
    end
    goto_cyc(t + 50);
    raw = 4'b0000;

    goto_cyc(t + 65);
    for (int w = 0; w < 50 && (ev_q.size() > 0 || snap_q.size() > 0); w++) begin
      @(posedge clk);
      #1;
    end
    while (ev_q.size() > 0) begin
      chk("strobe_never_seen", cyc, 32'h1, 32'h0);
      void'(ev_q.pop_front());
    end
    while (snap_q.size() > 0) begin
      chk("snapshot_never_taken", cyc, 32'h1, 32'h0);
      void'(snap_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
